// File: rtl/cart_sdram_sched.sv
// Arbitrates the cartridge SDRAM port between the ROM download writer and the
// console read bus, with a one-word tagged read buffer in front of the port.
module cart_sdram_sched #(
    parameter int unsigned AW         = 24,
    parameter int unsigned CART_AW    = 15,
    parameter int unsigned SMALL_BITS = 13
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               dl_active,
    input  logic               dl_index0,
    input  logic               dl_wr,
    input  logic [24:0]        dl_addr,
    input  logic [7:0]         dl_data,
    output logic               dl_ovf,
    input  logic               cart_rd,
    input  logic [CART_AW-1:0] cart_addr,
    output logic [7:0]         cart_do,
    output logic               cart_valid,
    output logic               sd_req,
    input  logic               sd_ack,
    output logic [AW-1:0]      sd_a,
    output logic               sd_we,
    output logic [1:0]         sd_ds,
    output logic [15:0]        sd_d,
    input  logic [15:0]        sd_q
);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    state_t state, state_nx;

    logic               done;
    logic               wr_in;
    logic [CART_AW-1:0] dl_map;
    logic               slot_full;
    logic [CART_AW-1:0] slot_addr;
    logic [7:0]         slot_data;
    logic               tag_valid;
    logic [CART_AW-2:0] tag;
    logic [CART_AW-2:0] rd_word;
    logic               rd_discard;
    logic [15:0]        rd_buf;
    logic               rd_miss;
    logic               issue_slot, issue_dl, issue_rd;
    logic               slot_load, slot_drop;
    logic [CART_AW-1:0] wr_addr;
    logic [7:0]         wr_data;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^dl_addr[24:CART_AW];

    assign done  = (sd_req == sd_ack);
    assign wr_in = dl_wr & dl_active;

    // Small ROMs land in the top of the cartridge window.
    always_comb begin
        dl_map = dl_addr[CART_AW-1:0];
        if (!dl_index0) begin
            dl_map                   = '1;
            dl_map[SMALL_BITS-1:0]   = dl_addr[SMALL_BITS-1:0];
        end
    end

    assign rd_miss = !dl_active && cart_rd &&
                     (!tag_valid || (tag != cart_addr[CART_AW-1:1]));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (issue_slot || issue_dl) state_nx = WR_WAIT;
                else if (issue_rd)          state_nx = RD_WAIT;
            end
            WR_WAIT: if (done) state_nx = IDLE;
            RD_WAIT: if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A queued byte always goes first, so writes drain before any read.
    always_comb begin
        issue_slot = (state == IDLE) && slot_full;
        issue_dl   = (state == IDLE) && !slot_full && wr_in;
        issue_rd   = (state == IDLE) && !slot_full && !wr_in && rd_miss;
        slot_load  = wr_in && (((state == IDLE) && slot_full) ||
                               ((state != IDLE) && !slot_full));
        slot_drop  = wr_in && (state != IDLE) && slot_full;
        wr_addr    = slot_full ? slot_addr : dl_map;
        wr_data    = slot_full ? slot_data : dl_data;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sd_req     <= 1'b0;
            sd_we      <= 1'b0;
            sd_a       <= '0;
            sd_ds      <= 2'b00;
            sd_d       <= '0;
            cart_do    <= '0;
            cart_valid <= 1'b0;
            dl_ovf     <= 1'b0;
            slot_full  <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
            tag_valid  <= 1'b0;
            tag        <= '0;
            rd_word    <= '0;
            rd_discard <= 1'b0;
            rd_buf     <= '0;
        end else begin
            if (issue_slot || issue_dl) begin
                sd_req <= ~sd_req;
                sd_a   <= AW'(wr_addr[CART_AW-1:1]);
                sd_we  <= 1'b1;
                sd_ds  <= {wr_addr[0], ~wr_addr[0]};
                sd_d   <= {wr_data, wr_data};
            end else if (issue_rd) begin
                sd_req  <= ~sd_req;
                sd_a    <= AW'(cart_addr[CART_AW-1:1]);
                sd_we   <= 1'b0;
                sd_ds   <= 2'b11;
                rd_word <= cart_addr[CART_AW-1:1];
            end

            if (slot_load) begin
                slot_full <= 1'b1;
                slot_addr <= dl_map;
                slot_data <= dl_data;
            end else if (issue_slot) begin
                slot_full <= 1'b0;
            end

            if (slot_drop) dl_ovf <= 1'b1;

            // A read overlapped by a download must not revalidate the tag.
            if (issue_rd)       rd_discard <= 1'b0;
            else if (dl_active) rd_discard <= 1'b1;

            if ((state == RD_WAIT) && done) begin
                rd_buf    <= sd_q;
                tag       <= rd_word;
                tag_valid <= !(rd_discard || dl_active);
            end else if (dl_active) begin
                tag_valid <= 1'b0;
            end

            cart_do    <= cart_addr[0] ? rd_buf[15:8] : rd_buf[7:0];
            cart_valid <= tag_valid && (tag == cart_addr[CART_AW-1:1]) && !dl_active;
        end
    end

endmodule
